// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector engine.
// Build option: MATVEC_SIGNED_EN selects two's-complement element arithmetic.
package matvec_pkg;

  // Job sequencing states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    COMPUTE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Result width: full-width products plus enough headroom for n additions.
  function automatic int calc_cw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matvec_mac_lane.sv
// One multiply-accumulate lane: acc += a*b when enabled, synchronous clear.
// Build option: MATVEC_SIGNED_EN treats a and b as two's-complement and
// sign-extends the product into the accumulator; otherwise unsigned.
module matvec_mac_lane #(
  parameter int DW = 8,
  parameter int CW = 19
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [CW-1:0] acc
);

  logic [2*DW-1:0] prod_s;
  logic [CW-1:0]   prod_ext_s;
  logic [CW-1:0]   acc_d;
  logic [CW-1:0]   acc_q;

`ifdef MATVEC_SIGNED_EN
  // Signed product at full width, then sign-extended to accumulator width.
  always_comb begin
    prod_s     = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    prod_ext_s = {{(CW-2*DW){prod_s[2*DW-1]}}, prod_s};
  end
`else
  // Unsigned product at full width, then zero-extended to accumulator width.
  always_comb begin
    prod_s     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    prod_ext_s = {{(CW-2*DW){1'b0}}, prod_s};
  end
`endif

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector engine: fetches vector B then N rows of A from memory
// (one outstanding read), then computes C = A*B with N parallel MAC lanes
// over N cycles. Results stay readable through res_idx/res_data.
// Build option: MATVEC_SIGNED_EN selects signed arithmetic in the lanes.
module matvec_engine import matvec_pkg::*; #(
  parameter  int N  = 8,
  parameter  int DW = 8,
  parameter  int AW = 32,
  localparam int CW = calc_cw(N, DW),
  localparam int IW = $clog2(N)
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     mem_address,
  output logic              mem_read,
  input  logic [N*DW-1:0]   mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  input  logic [IW-1:0]     res_idx,
  output logic [CW-1:0]     res_data
);

  localparam int RW = $clog2(N + 1);

  typedef logic [N-1:0][DW-1:0] row_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [IW-1:0]        k_q, k_d;
  logic [AW-1:0]        base_q, base_d;
  logic [AW-1:0]        mem_address_q, mem_address_d;
  logic                 mem_read_q, mem_read_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  row_t                 b_q, b_d;
  logic [N-1:0][N-1:0][DW-1:0] a_q, a_d;
  row_t                 row_s;
  logic                 lane_clr_s;
  logic                 lane_en_s;
  logic [N-1:0][CW-1:0] acc_s;

  // Unpack the memory word: element 0 sits in the most-significant bits.
  always_comb begin
    row_s = '0;
    for (int j = 0; j < N; j++) begin
      row_s[j] = mem_readdata[(N-1-j)*DW +: DW];
    end
  end

  // Sequencer: next state, memory request, buffer loads and lane control.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    k_d           = k_q;
    base_d        = base_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    b_d           = b_q;
    a_d           = a_q;
    lane_clr_s    = 1'b0;
    lane_en_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d        = base_addr;
          mem_address_d = base_addr;
          mem_read_d    = 1'b1;
          row_d         = '0;
          k_d           = '0;
          b_d           = '0;
          a_d           = '0;
          lane_clr_s    = 1'b1;
          busy_d        = 1'b1;
          state_d       = REQ;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      REQ: begin
        // Request and address stay put until the memory takes them.
        if (mem_read_q && !mem_waitrequest) begin
          mem_read_d = 1'b0;
          state_d    = WAIT_DATA;
        end else begin
          mem_read_d = 1'b1;
          state_d    = REQ;
        end
      end
      WAIT_DATA: begin
        if (mem_readdatavalid) begin
          if (row_q == '0) begin
            b_d = row_s;
          end else begin
            for (int r = 0; r < N; r++) begin
              a_d[r] = (row_q == RW'(r + 1)) ? row_s : a_q[r];
            end
          end
          if (row_q == RW'(N)) begin
            k_d     = '0;
            state_d = COMPUTE;
          end else begin
            row_d         = row_q + RW'(1'b1);
            mem_address_d = base_q + AW'(row_q) + AW'(1'b1);
            mem_read_d    = 1'b1;
            state_d       = REQ;
          end
        end else begin
          state_d = WAIT_DATA;
        end
      end
      COMPUTE: begin
        lane_en_s = 1'b1;
        k_d       = k_q + IW'(1'b1);
        if (k_q == IW'(N - 1)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = COMPUTE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        mem_read_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // Sequencer and buffer registers; reset abandons any job in flight.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      row_q         <= '0;
      k_q           <= '0;
      base_q        <= '0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      b_q           <= '0;
      a_q           <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      k_q           <= k_d;
      base_q        <= base_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      b_q           <= b_d;
      a_q           <= a_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    matvec_mac_lane #(
      .DW(DW),
      .CW(CW)
    ) u_lane (
      .CLOCK_50(CLOCK_50),
      .rst_n   (rst_n),
      .clr     (lane_clr_s),
      .en      (lane_en_s),
      .a       (a_q[gi][k_q]),
      .b       (b_q[k_q]),
      .acc     (acc_s[gi])
    );
  end

  // Result read port; an out-of-range select reads zero.
  always_comb begin
    res_data = '0;
    for (int i = 0; i < N; i++) begin
      res_data = (res_idx == IW'(i)) ? acc_s[i] : res_data;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;

endmodule

// File: doc/matvec_engine.md
MATVEC_ENGINE -- requirements
Module: matvec_engine

Interface
REQ-001 SHALL have parameter N, default 8, meaning vector length, matrix row count and MAC lane count (N >= 2).
REQ-002 SHALL have parameter DW, default 8, meaning element width in bits.
REQ-003 SHALL have parameter AW, default 32, meaning memory word-address width.
REQ-004 SHALL derive CW = 2*DW + clog2(N), the result width.
REQ-005 SHALL have port CLOCK_50  in  1  clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle request to begin a job.
REQ-008 SHALL have port base_addr  in  AW  word address of vector B; rows of A follow at base_addr+1 .. base_addr+N.
REQ-009 SHALL have port busy  out  1  high from job acceptance until done.
REQ-010 SHALL have port done  out  1  one-cycle pulse when results are valid.
REQ-011 SHALL have port mem_address  out  AW  memory word address.
REQ-012 SHALL have port mem_read  out  1  read request.
REQ-013 SHALL have port mem_readdata  in  N*DW  one row; element 0 is the most-significant DW bits.
REQ-014 SHALL have port mem_readdatavalid  in  1  mem_readdata is valid this cycle.
REQ-015 SHALL have port mem_waitrequest  in  1  memory stall; the request is not accepted while high.
REQ-016 SHALL have port res_idx  in  clog2(N)  result select.
REQ-017 SHALL have port res_data  out  CW  combinational C[res_idx].

Function
REQ-018 SHALL use states IDLE, REQ, WAIT_DATA, COMPUTE, DONE.
REQ-019 IDLE: on start, SHALL clear row counter, all buffers and accumulators, then go to REQ; busy goes high the next cycle.
REQ-020 SHALL ignore start unless in IDLE; the in-flight job is unaffected.
REQ-021 REQ: SHALL assert mem_read with mem_address = base_addr + row (row 0..N), captured at start, holding both stable while mem_waitrequest is high.
REQ-022 REQ: on a cycle with mem_read high and mem_waitrequest low, SHALL drop mem_read next cycle and go to WAIT_DATA; at most one read is outstanding.
REQ-023 WAIT_DATA: on mem_readdatavalid, SHALL write row 0 into vector buffer B[0..N-1] and row r>=1 into A[r-1][0..N-1].
REQ-024 WAIT_DATA: SHALL return to REQ if row < N, else go to COMPUTE.
REQ-025 SHALL ignore mem_readdatavalid outside WAIT_DATA.
REQ-026 COMPUTE: SHALL run exactly N cycles, k = 0..N-1; in cycle k every lane i does C[i] += A[i][k]*B[k] in parallel.
REQ-027 SHALL compute products at full 2*DW width and accumulate at CW width; overflow is impossible by construction.
REQ-028 After the N-th COMPUTE cycle, SHALL enter DONE for one cycle asserting done, then return to IDLE with busy low.
REQ-029 SHALL hold results until the next accepted start; res_data is readable at any time.
REQ-030 Job latency from start to done SHALL be (N+1)*(3 + stall cycles + response delay) + N + 1 cycles or fewer.

Reset
REQ-031 On rst_n low, SHALL return the FSM to IDLE asynchronously.
REQ-032 On rst_n low, busy, done and mem_read SHALL be 0, mem_address SHALL be 0, and all buffers and accumulators SHALL be 0; res_data therefore reads 0.
REQ-033 Reset mid-job SHALL abandon the job; a memory response arriving after reset SHALL be ignored.

Configuration
REQ-034 With MATVEC_SIGNED_EN defined, elements SHALL be two's-complement signed and products and accumulation sign-extended.
REQ-035 Without MATVEC_SIGNED_EN, all arithmetic SHALL be unsigned; ports and widths are identical in both builds.

Structure
REQ-036 Package matvec_pkg SHALL hold the state enum type and a constant function for CW.
REQ-037 SHALL instantiate N copies of sub-module matvec_mac_lane (multiply, accumulate, synchronous clear, enable) via generate.
REQ-038 Buffers SHALL be register arrays; no vendor FIFO IP.

Verification
REQ-039 Nominal, N=8, DW=8: B all 2, A all 1, no stalls -> done once; res_data = 16 for every idx; 9 reads at base_addr..base_addr+8.
REQ-040 Maximum values: all elements 0xFF, unsigned build -> every result 520200 (0x7F008), no truncation at CW=19.
REQ-041 Stall: mem_waitrequest high 3 cycles on row 4 -> mem_address and mem_read stable across the stall; results unchanged vs the no-stall run.
REQ-042 Reset mid-COMPUTE, then new job with A[i][k]=i, B[k]=1 -> the first job's done never fires; new res_data[i] = 8*i.
REQ-043 start pulsed while busy -> ignored; exactly one done; base_addr change mid-job has no effect.
REQ-044 MATVEC_SIGNED_EN build: A all 0xFF (-1), B all 0x02 -> every res_data = -16 (0x7FFF0 in 19 bits).
